// File: rtl/alu_issue_unit.sv
// Two-stage issue unit in front of an external 32-bit RISC-V ALU: decode into E, capture result in R.
// Optional overflow trap enabled by defining ALU_OVF_TRAP_EN (adds port out_ovf_trap).
module alu_issue_unit #(
  parameter int Width = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_opcode,
  input  logic [2:0]       in_funct3,
  input  logic             in_funct7b5,
  input  logic [Width-1:0] in_pc,
  input  logic [Width-1:0] in_rs1,
  input  logic [Width-1:0] in_rs2,
  input  logic [Width-1:0] in_imm,
  input  logic [4:0]       in_rd,
  input  logic             flush,
  output logic [3:0]       alu_ctrl,
  output logic [Width-1:0] alu_a,
  output logic [Width-1:0] alu_b,
  input  logic [Width-1:0] alu_y,
  input  logic             alu_zero,
  input  logic             alu_carry,
  input  logic             alu_overflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Width-1:0] out_result,
  output logic [4:0]       out_rd,
  output logic             out_we,
  output logic             out_mem,
  output logic             out_br_taken,
  output logic [Width-1:0] out_br_target,
`ifdef ALU_OVF_TRAP_EN
  output logic             out_ovf_trap,
`endif
  output logic             out_illegal
);

  localparam logic [3:0] C_AND = 4'b0000, C_OR = 4'b0001, C_ADD = 4'b0010, C_SLL = 4'b0011,
                         C_SLT = 4'b0100, C_SLTU = 4'b0101, C_SUB = 4'b0110, C_XOR = 4'b0111,
                         C_SRL = 4'b1000, C_SRA = 4'b1010;

  logic [3:0]       dec_ctrl;
  logic [Width-1:0] dec_a, dec_b;
  logic             dec_we, dec_mem, dec_br, dec_ill, dec_ovf;

  logic             e_valid, r_valid;
  logic [3:0]       e_ctrl;
  logic [Width-1:0] e_a, e_b, e_pc4, e_target;
  logic [4:0]       e_rd;
  logic             e_we, e_mem, e_br, e_br_lt, e_br_inv, e_ill;
  logic             e_advance, accept, br_cond, taken;

  // Shared funct3 -> ALU op table for R and I formats; funct7b5 only matters for SUB/SRA.
  function automatic logic [3:0] arith_ctrl(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  arith_ctrl = alt ? C_SUB : C_ADD;
      3'b001:  arith_ctrl = C_SLL;
      3'b010:  arith_ctrl = C_SLT;
      3'b011:  arith_ctrl = C_SLTU;
      3'b100:  arith_ctrl = C_XOR;
      3'b101:  arith_ctrl = alt ? C_SRA : C_SRL;
      3'b110:  arith_ctrl = C_OR;
      default: arith_ctrl = C_AND;
    endcase
  endfunction

  always_comb begin
    dec_ctrl = C_ADD;
    dec_a    = in_rs1;
    dec_b    = in_rs2;
    dec_we   = 1'b0;
    dec_mem  = 1'b0;
    dec_br   = 1'b0;
    dec_ill  = 1'b0;
    dec_ovf  = 1'b0;
    case (in_opcode)
      7'b0110011: begin
        dec_we   = 1'b1;
        dec_ctrl = arith_ctrl(in_funct3, in_funct7b5);
        dec_ovf  = (in_funct3 == 3'b000);
        if (in_funct3 == 3'b001 || in_funct3 == 3'b101)
          dec_b = {{(Width-5){1'b0}}, in_rs2[4:0]};
        if (in_funct7b5 && in_funct3 != 3'b000 && in_funct3 != 3'b101)
          dec_ill = 1'b1;
      end
      7'b0010011: begin
        // imm[10] aliases funct7b5, so it only selects SRAI, never SUBI.
        dec_we   = 1'b1;
        dec_b    = in_imm;
        dec_ctrl = arith_ctrl(in_funct3, in_funct7b5 && in_funct3 == 3'b101);
        if (in_funct3 == 3'b001 || in_funct3 == 3'b101)
          dec_b = {{(Width-5){1'b0}}, in_imm[4:0]};
      end
      7'b0000011, 7'b0100011: begin
        dec_b   = in_imm;
        dec_mem = 1'b1;
      end
      7'b0110111: begin
        dec_a  = '0;
        dec_b  = in_imm;
        dec_we = 1'b1;
      end
      7'b0010111: begin
        dec_a  = in_pc;
        dec_b  = in_imm;
        dec_we = 1'b1;
      end
      7'b1100011: begin
        dec_br = 1'b1;
        case (in_funct3[2:1])
          2'b00:   dec_ctrl = C_SUB;
          2'b10:   dec_ctrl = C_SLT;
          2'b11:   dec_ctrl = C_SLTU;
          default: dec_ill  = 1'b1;
        endcase
      end
      default: dec_ill = 1'b1;
    endcase
    if (dec_ill) begin
      dec_ctrl = C_ADD;
      dec_we   = 1'b0;
      dec_mem  = 1'b0;
      dec_br   = 1'b0;
      dec_ovf  = 1'b0;
    end
  end

  assign e_advance = e_valid && (!r_valid || out_ready);
  assign in_ready  = !e_valid || e_advance;
  assign accept    = in_valid && in_ready;
  assign alu_ctrl  = e_ctrl;
  assign alu_a     = e_a;
  assign alu_b     = e_b;
  assign out_valid = r_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_valid <= 1'b0;  e_ctrl <= '0;     e_a <= '0;       e_b <= '0;
      e_pc4 <= '0;      e_target <= '0;   e_rd <= '0;      e_we <= 1'b0;
      e_mem <= 1'b0;    e_br <= 1'b0;     e_br_lt <= 1'b0; e_br_inv <= 1'b0;
      e_ill <= 1'b0;
    end else if (flush) begin
      e_valid <= 1'b0;
    end else if (accept) begin
      e_valid  <= 1'b1;
      e_ctrl   <= dec_ctrl;
      e_a      <= dec_a;
      e_b      <= dec_b;
      e_pc4    <= in_pc + Width'(4);
      e_target <= in_pc + in_imm;
      e_rd     <= in_rd;
      e_we     <= dec_we;
      e_mem    <= dec_mem;
      e_br     <= dec_br;
      e_br_lt  <= in_funct3[2];
      e_br_inv <= in_funct3[0];
      e_ill    <= dec_ill;
    end else if (e_advance) begin
      e_valid <= 1'b0;
    end
  end

  // Odd funct3 inverts the base condition (BNE/BGE/BGEU).
  assign br_cond = e_br_lt ? alu_y[0] : alu_zero;
  assign taken   = e_br && (br_cond ^ e_br_inv);

`ifdef ALU_OVF_TRAP_EN
  logic e_ovf, trap, unused_flags;
  assign trap         = e_ovf && alu_overflow;
  assign unused_flags = alu_carry;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    e_ovf <= 1'b0;
    else if (!flush && accept)    e_ovf <= dec_ovf;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    out_ovf_trap <= 1'b0;
    else if (!flush && e_advance) out_ovf_trap <= trap;
  end
`else
  logic trap, unused_flags;
  assign trap         = 1'b0;
  assign unused_flags = ^{alu_carry, alu_overflow, dec_ovf};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;      out_result <= '0;  out_rd <= '0;        out_we <= 1'b0;
      out_mem <= 1'b0;      out_br_taken <= 1'b0;  out_br_target <= '0;  out_illegal <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (e_advance) begin
      r_valid       <= 1'b1;
      out_result    <= e_br ? e_pc4 : alu_y;
      out_rd        <= e_rd;
      out_we        <= e_we && !trap;
      out_mem       <= e_mem;
      out_br_taken  <= taken;
      out_br_target <= e_target;
      out_illegal   <= e_ill;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Bench for alu_issue_unit: behavioural ALU, vector table, scoreboard queue, hand-written stall/flush/reset sequences.
module tb_alu_issue_unit;
  localparam int W = 32;
`ifdef ALU_OVF_TRAP_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic clk = 1'b0, reset = 1'b1;
  logic in_valid = 1'b0, in_ready, in_funct7b5 = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [6:0] in_opcode = '0;
  logic [2:0] in_funct3 = '0;
  logic [W-1:0] in_pc = '0, in_rs1 = '0, in_rs2 = '0, in_imm = '0;
  logic [4:0] in_rd = '0;
  logic [3:0] alu_ctrl;
  logic [W-1:0] alu_a, alu_b, alu_y;
  logic alu_zero, alu_carry, alu_overflow;
  logic out_valid, out_we, out_mem, out_br_taken, out_illegal, trap_out;
  logic [W-1:0] out_result, out_br_target;
  logic [4:0] out_rd;

  always #5 clk = ~clk;

  alu_issue_unit #(.Width(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
    .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_rd(in_rd),
    .flush(flush), .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y),
    .alu_zero(alu_zero), .alu_carry(alu_carry), .alu_overflow(alu_overflow),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_rd(out_rd),
    .out_we(out_we), .out_mem(out_mem), .out_br_taken(out_br_taken),
    .out_br_target(out_br_target),
`ifdef ALU_OVF_TRAP_EN
    .out_ovf_trap(trap_out),
`endif
    .out_illegal(out_illegal)
  );
`ifndef ALU_OVF_TRAP_EN
  assign trap_out = 1'b0;
`endif

  // Behavioural ALU; shifts use the full B operand so an unmasked shift amount is visible.
  always_comb begin
    alu_y = '0;
    alu_carry = 1'b0;
    alu_overflow = 1'b0;
    case (alu_ctrl)
      4'b0000: alu_y = alu_a & alu_b;
      4'b0001: alu_y = alu_a | alu_b;
      4'b0010: begin
        {alu_carry, alu_y} = {1'b0, alu_a} + {1'b0, alu_b};
        alu_overflow = (alu_a[W-1] == alu_b[W-1]) && (alu_y[W-1] != alu_a[W-1]);
      end
      4'b0011: alu_y = alu_a << alu_b;
      4'b0100: alu_y = {31'd0, $signed(alu_a) < $signed(alu_b)};
      4'b0101: alu_y = {31'd0, alu_a < alu_b};
      4'b0110: begin
        {alu_carry, alu_y} = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
        alu_overflow = (alu_a[W-1] != alu_b[W-1]) && (alu_y[W-1] != alu_a[W-1]);
      end
      4'b0111: alu_y = alu_a ^ alu_b;
      4'b1000: alu_y = alu_a >> alu_b;
      4'b1010: alu_y = $signed(alu_a) >>> alu_b;
      default: alu_y = '0;
    endcase
  end
  assign alu_zero = (alu_y == '0);

  typedef struct {
    logic [6:0] op; logic [2:0] f3; logic f7;
    logic [W-1:0] pc, rs1, rs2, imm; logic [4:0] rd;
    logic [W-1:0] res; logic chk; logic we, mem, tk, ill, trap;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int total = 0, bad = 0;

  function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                              input logic [W-1:0] pc, rs1, rs2, imm, res,
                              input logic chk, we, mem, tk, ill, trap);
    vec_t v;
    v.op = op; v.f3 = f3; v.f7 = f7; v.pc = pc; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm;
    v.rd = 5'(tbl.size() + 1); v.res = res; v.chk = chk;
    v.we = we; v.mem = mem; v.tk = tk; v.ill = ill; v.trap = trap;
    return v;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s got=%h required=%h", name, got, req);
    end
  endtask

  task automatic mon();
    vec_t e;
    logic [W-1:0] gr;
    if (out_valid && out_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_output got rd=%0d result=%h required=no output", out_rd, out_result);
      end else begin
        e = exp_q.pop_front();
        gr = e.chk ? out_result : e.res;
        if ({gr, out_rd, out_we, out_mem, out_br_taken, out_br_target, out_illegal, trap_out} !==
            {e.res, e.rd, e.we, e.mem, e.tk, e.pc + e.imm, e.ill, e.trap}) begin
          bad++;
          $display("FAIL txn_rd%0d got res=%h we=%b mem=%b tk=%b tgt=%h ill=%b trap=%b required res=%h we=%b mem=%b tk=%b tgt=%h ill=%b trap=%b",
                   e.rd, out_result, out_we, out_mem, out_br_taken, out_br_target, out_illegal, trap_out,
                   e.res, e.we, e.mem, e.tk, e.pc + e.imm, e.ill, e.trap);
        end else
          $display("txn rd=%0d res=%h we=%b mem=%b tk=%b tgt=%h ill=%b", e.rd, out_result, out_we,
                   out_mem, out_br_taken, out_br_target, out_illegal);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk); mon();
    @(posedge clk); #1;
  endtask

  task automatic drive(input vec_t v);
    in_opcode = v.op; in_funct3 = v.f3; in_funct7b5 = v.f7; in_pc = v.pc;
    in_rs1 = v.rs1; in_rs2 = v.rs2; in_imm = v.imm; in_rd = v.rd; in_valid = 1'b1;
  endtask

  // Returns #1 after the accepting edge; waits = cycles in_ready was low.
  task automatic issue(input vec_t v, output int waits);
    logic ok;
    drive(v);
    waits = 0;
    ok = 1'b0;
    while (!ok) begin
      @(negedge clk); mon();
      ok = in_ready;
      @(posedge clk); #1;
      if (!ok) begin
        waits++;
        if (waits > 50) begin
          total++; bad++;
          $display("FAIL accept_timeout got in_ready=0 required=1");
          break;
        end
      end
    end
    if (ok) exp_q.push_back(v);
    in_valid = 1'b0;
  endtask

  initial begin
    int w;
    vec_t x1, x2, x3;
    // op, f3, f7, pc, rs1, rs2, imm, result, chk, we, mem, tk, ill, trap
    tbl.push_back(mk(7'b0110011, 3'b000, 0, 0, 7, 5, 0, 12, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(7'b0110011, 3'b000, 1, 0, 3, 5, 0, 32'hFFFFFFFE, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(7'b0110011, 3'b101, 1, 0, 32'h80000000, 36, 0, 32'hF8000000, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(7'b0110011, 3'b010, 0, 0, 32'hFFFFFFFF, 1, 0, 1, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(7'b0110011, 3'b011, 0, 0, 32'hFFFFFFFF, 1, 0, 0, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(7'b0110011, 3'b100, 0, 0, 32'hF0F0, 32'h0FF0, 0, 32'hFF00, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(7'b0110011, 3'b001, 0, 0, 1, 33, 0, 2, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(7'b0110011, 3'b101, 0, 0, 32'h80000000, 4, 0, 32'h08000000, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(7'b0110011, 3'b110, 0, 0, 32'h0F00, 32'h00F0, 0, 32'h0FF0, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(7'b0110011, 3'b111, 0, 0, 32'hFF, 32'h0F, 0, 32'h0F, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(7'b0010011, 3'b000, 1, 0, 2000, 77, 32'hFFFFFC00, 976, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(7'b0010011, 3'b101, 1, 0, 32'h80000000, 99, 32'h403, 32'hF0000000, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(7'b0010011, 3'b011, 0, 0, 5, 0, 32'hFFFFFFFF, 1, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(7'b0000011, 3'b010, 0, 0, 32'h1000, 3, 32'hFFFFFFFC, 32'hFFC, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(7'b0100011, 3'b010, 0, 0, 32'h200, 3, 8, 32'h208, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(7'b0110111, 3'b000, 0, 0, 32'h999, 0, 32'h12345000, 32'h12345000, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(7'b0010111, 3'b000, 0, 32'h400, 9, 0, 32'h1000, 32'h1400, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(7'b1100011, 3'b001, 0, 32'h100, 9, 9, 32'h20, 32'h104, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(7'b1100011, 3'b000, 0, 32'h100, 9, 9, 32'h20, 32'h104, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(7'b1100011, 3'b110, 0, 32'h200, 1, 2, 32'hFFFFFFF0, 32'h204, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(7'b1100011, 3'b101, 0, 32'h10, 32'hFFFFFFFF, 1, 4, 32'h14, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(7'b1100011, 3'b100, 0, 32'h10, 32'hFFFFFFFF, 1, 4, 32'h14, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(7'b1100011, 3'b111, 0, 32'h10, 5, 5, 4, 32'h14, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(7'b1100011, 3'b000, 0, 32'hFFFFFFFC, 1, 2, 8, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(7'b0000000, 3'b000, 0, 0, 1, 2, 3, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(7'b1100011, 3'b010, 0, 0, 4, 4, 3, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(7'b0110011, 3'b001, 1, 0, 1, 2, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(7'b0110011, 3'b000, 0, 0, 32'h7FFFFFFF, 1, 0, 32'h80000000, 1, !OVF_EN, 0, 0, 0, OVF_EN));

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_alu_ctrl", 32'(alu_ctrl), 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    reset = 1'b0;
    tick();

    // First ADD: ALU drive from E and two-edge latency
    out_ready = 1'b1;
    issue(tbl[0], w);
    chk("add_alu_ctrl", 32'(alu_ctrl), 32'h2);
    chk("add_alu_a", alu_a, 7);
    chk("add_alu_b", alu_b, 5);
    chk("add_valid_n", 32'(out_valid), 0);
    tick();
    chk("add_valid_n1", 32'(out_valid), 1);
    tick();

    // Whole table back-to-back: every entry must be accepted without a stall
    foreach (tbl[i]) begin
      issue(tbl[i], w);
      chk($sformatf("tput_%0d", i), 32'(w), 0);
    end
    repeat (3) tick();

    // Stall: three issues with consumer blocked
    x1 = tbl[1]; x2 = tbl[2]; x3 = tbl[5];
    out_ready = 1'b0;
    issue(x1, w); chk("stall_w1", 32'(w), 0);
    issue(x2, w); chk("stall_w2", 32'(w), 0);
    drive(x3);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); mon();
      chk($sformatf("stall_in_ready_%0d", c), 32'(in_ready), 0);
      chk($sformatf("stall_hold_%0d", c), 32'(out_valid), 1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    issue(x3, w);
    chk("stall_w3", 32'(w), 0);
    repeat (4) tick();
    chk("stall_drained", 32'(exp_q.size()), 0);

    // Flush with E and R both occupied; the same-cycle instruction is dropped
    out_ready = 1'b0;
    issue(tbl[3], w);
    issue(tbl[4], w);
    drive(tbl[6]);
    flush = 1'b1;
    @(negedge clk); mon();
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    chk("flush_out_valid", 32'(out_valid), 0);
    chk("flush_in_ready", 32'(in_ready), 1);
    tick();
    chk("flush_no_ghost", 32'(out_valid), 0);
    out_ready = 1'b1;
    tick();
    chk("flush_no_ghost2", 32'(out_valid), 0);

    // Asynchronous reset while stalled
    out_ready = 1'b0;
    issue(tbl[7], w);
    issue(tbl[8], w);
    #2 reset = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 0);
    chk("arst_alu_ctrl", 32'(alu_ctrl), 0);
    chk("arst_out_result", out_result, 0);
    exp_q.delete();
    tick();
    reset = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    chk("arst_idle", 32'(out_valid), 0);
    issue(tbl[9], w);
    tick();
    chk("arst_recover", 32'(out_valid), 1);

    // Drain, bounded
    for (int c = 0; c < 50 && exp_q.size() != 0; c++) tick();
    chk("final_queue_empty", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
